// File: rtl/axi_slice_dc_pwr_pkg.sv
// Shared types and default parameter values for the dc-slice power controller.
package axi_slice_dc_pwr_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ISOLATE  = 2'd1,
        CLK_DOWN = 2'd2,
        WAKE     = 2'd3
    } pwr_state_e;

    localparam int DEF_MAX_OUTSTANDING = 16;
    localparam int DEF_WAKE_DELAY      = 4;
    localparam int DEF_DRAIN_TIMEOUT   = 1024;

endpackage

// File: rtl/axi_slice_dc_outstanding_cnt.sv
// Saturating up/down counter of in-flight AXI transactions; err_o flags an
// over/underflow attempt in the current cycle (made sticky by the parent).
module axi_slice_dc_outstanding_cnt
    import axi_slice_dc_pwr_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_s;

    // Next count: saturate at both ends, simultaneous inc/dec cancel.
    always_comb begin
        cnt_d = cnt_q;
        err_s = 1'b0;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            case ({inc_i, dec_i})
                2'b10: begin
                    if (cnt_q == CNT_W'(MAX_OUTSTANDING)) begin
                        err_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        err_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_s;

endmodule

// File: rtl/axi_slice_dc_pwr_ctrl.sv
// Power-down sequencer for an AXI dc slice: drain, isolate, gate clock, wake.
// Optional drain timeout enabled by defining AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN.
module axi_slice_dc_pwr_ctrl
    import axi_slice_dc_pwr_pkg::*;
#(
    parameter int  MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int  WAKE_DELAY      = DEF_WAKE_DELAY,
    parameter int  DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sleep_req_i,
    input  logic             incoming_req_i,
    input  logic             aw_hs_i,
    input  logic             ar_hs_i,
    input  logic             b_hs_i,
    input  logic             r_last_hs_i,
    output logic             isolate_o,
    output logic             clock_down_o,
    output logic             clk_en_o,
    output logic             sleep_ack_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic             cnt_err_o,
    output logic             timeout_o
);

    localparam int WK_W = $clog2(WAKE_DELAY + 1);

    pwr_state_e       state_d, state_q;
    logic [WK_W-1:0]  wake_cnt_d, wake_cnt_q;
    logic             isolate_d, isolate_q;
    logic             clock_down_d, clock_down_q;
    logic             clk_en_d, clk_en_q;
    logic             sleep_ack_d, sleep_ack_q;
    logic             cnt_err_d, cnt_err_q;
    logic             wr_err_s, rd_err_s;
    logic             cnt_clr_s;
    logic             drained_s;

`ifdef AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
    logic [TO_W-1:0]  to_cnt_d, to_cnt_q;
    logic             timeout_d, timeout_q;
`endif

    axi_slice_dc_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_wr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (aw_hs_i),
        .dec_i (b_hs_i),
        .clr_i (cnt_clr_s),
        .cnt_o (wr_cnt_o),
        .err_o (wr_err_s)
    );

    axi_slice_dc_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_rd_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ar_hs_i),
        .dec_i (r_last_hs_i),
        .clr_i (cnt_clr_s),
        .cnt_o (rd_cnt_o),
        .err_o (rd_err_s)
    );

    assign drained_s = (wr_cnt_o == {CNT_W{1'b0}}) && (rd_cnt_o == {CNT_W{1'b0}});

    // Next-state logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        cnt_clr_s  = 1'b0;
        case (state_q)
            RUN: begin
                if (sleep_req_i && !incoming_req_i) begin
                    state_d = ISOLATE;
                end else begin
                    state_d = RUN;
                end
            end
            ISOLATE: begin
                if (!sleep_req_i || incoming_req_i) begin
                    state_d = RUN;
                end else if (drained_s) begin
                    state_d = CLK_DOWN;
                end
`ifdef AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d   = CLK_DOWN;
                    cnt_clr_s = 1'b1;
                end
`endif
                else begin
                    state_d = ISOLATE;
                end
            end
            CLK_DOWN: begin
                if (incoming_req_i || !sleep_req_i) begin
                    state_d    = WAKE;
                    wake_cnt_d = {WK_W{1'b0}};
                end else begin
                    state_d = CLK_DOWN;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WK_W'(WAKE_DELAY - 1)) begin
                    state_d    = RUN;
                    wake_cnt_d = {WK_W{1'b0}};
                end else begin
                    wake_cnt_d = wake_cnt_q + WK_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wake_cnt_d = {WK_W{1'b0}};
            end
        endcase

        isolate_d    = (state_d != RUN);
        clock_down_d = (state_d == CLK_DOWN) || (state_d == WAKE);
        clk_en_d     = (state_d != CLK_DOWN);
        sleep_ack_d  = (state_d == CLK_DOWN);
        cnt_err_d    = cnt_err_q | wr_err_s | rd_err_s;
    end

`ifdef AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN
    // Drain timer runs only while staying in ISOLATE; timeout flag is sticky.
    always_comb begin
        timeout_d = timeout_q | cnt_clr_s;
        if ((state_q == ISOLATE) && (state_d == ISOLATE)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end
    end

    // Timeout registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q  <= {TO_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // Timeout feature absent: constant zero.
    assign timeout_o = 1'b0 & (DRAIN_TIMEOUT < 0);
`endif

    // State, wake timer and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            wake_cnt_q   <= {WK_W{1'b0}};
            isolate_q    <= 1'b0;
            clock_down_q <= 1'b0;
            clk_en_q     <= 1'b1;
            sleep_ack_q  <= 1'b0;
            cnt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wake_cnt_q   <= wake_cnt_d;
            isolate_q    <= isolate_d;
            clock_down_q <= clock_down_d;
            clk_en_q     <= clk_en_d;
            sleep_ack_q  <= sleep_ack_d;
            cnt_err_q    <= cnt_err_d;
        end
    end

    assign isolate_o    = isolate_q;
    assign clock_down_o = clock_down_q;
    assign clk_en_o     = clk_en_q;
    assign sleep_ack_o  = sleep_ack_q;
    assign cnt_err_o    = cnt_err_q;

endmodule

// File: tb/tb_axi_slice_dc_pwr_ctrl.sv
// Directed scoreboard bench for axi_slice_dc_pwr_ctrl (small MAX_OUTSTANDING to reach saturation).
module tb_axi_slice_dc_pwr_ctrl;

    localparam int MAXO = 4;
    localparam int WD   = 4;
    localparam int DT   = 8;
    localparam int CW   = $clog2(MAXO + 1);

    // {isolate, clock_down, clk_en, sleep_ack} per state
    localparam logic [3:0] S_RUN = 4'b0010;
    localparam logic [3:0] S_ISO = 4'b1010;
    localparam logic [3:0] S_CD  = 4'b1101;
    localparam logic [3:0] S_WK  = 4'b1110;

    logic          clk = 1'b0;
    logic          rst, sr, inc, aw, ar, b, rl;
    logic          isolate_o, clock_down_o, clk_en_o, sleep_ack_o, cnt_err_o, timeout_o;
    logic [CW-1:0] wr_cnt_o, rd_cnt_o;

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_to      = 1'b0;

    typedef struct {
        string      tag;
        logic [3:0] st;
        int         wr;
        int         rd;
        logic       err;
        logic       to;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    axi_slice_dc_pwr_ctrl #(
        .MAX_OUTSTANDING (MAXO),
        .WAKE_DELAY      (WD),
        .DRAIN_TIMEOUT   (DT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sleep_req_i    (sr),
        .incoming_req_i (inc),
        .aw_hs_i        (aw),
        .ar_hs_i        (ar),
        .b_hs_i         (b),
        .r_last_hs_i    (rl),
        .isolate_o      (isolate_o),
        .clock_down_o   (clock_down_o),
        .clk_en_o       (clk_en_o),
        .sleep_ack_o    (sleep_ack_o),
        .wr_cnt_o       (wr_cnt_o),
        .rd_cnt_o       (rd_cnt_o),
        .cnt_err_o      (cnt_err_o),
        .timeout_o      (timeout_o)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s %s observed=%0h expected=%0h", tag, fld, got, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk(e.tag, "iso/cdn/clken/ack", {28'd0, isolate_o, clock_down_o, clk_en_o, sleep_ack_o}, {28'd0, e.st});
        chk(e.tag, "wr_cnt", {{(32-CW){1'b0}}, wr_cnt_o}, e.wr);
        chk(e.tag, "rd_cnt", {{(32-CW){1'b0}}, rd_cnt_o}, e.rd);
        chk(e.tag, "cnt_err", {31'd0, cnt_err_o}, {31'd0, e.err});
        chk(e.tag, "timeout", {31'd0, timeout_o}, {31'd0, e.to});
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input string tag, input logic s, input logic i, input logic w, input logic bb,
                        input logic a, input logic r, input logic [3:0] st, input int wr, input int rd,
                        input logic err);
        exp_t e;
        sr = s; inc = i; aw = w; b = bb; ar = a; rl = r;
        e.tag = tag; e.st = st; e.wr = wr; e.rd = rd; e.err = err; e.to = exp_to;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk_all(e);
    endtask

    task automatic chk_reset(input string tag);
        exp_t e;
        e.tag = tag; e.st = S_RUN; e.wr = 0; e.rd = 0; e.err = 1'b0; e.to = 1'b0;
        chk_all(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sr = 1'b0; inc = 1'b0; aw = 1'b0; ar = 1'b0; b = 1'b0; rl = 1'b0;
        #3;
        chk_reset("reset_async");
        @(posedge clk);
        #1;
        chk_reset("reset_clocked");
        rst = 1'b0;

        // Idle power-down and wake via incoming request
        step("idle_run",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 0, 0, 1'b0);
        step("sleep_iso",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ISO, 0, 0, 1'b0);
        step("sleep_cd",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CD,  0, 0, 1'b0);
        step("cd_hold",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CD,  0, 0, 1'b0);
        step("wake_inc",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_WK,  0, 0, 1'b0);
        for (int k = 0; k < WD - 1; k++)
            step("wake_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_WK, 0, 0, 1'b0);
        step("wake_run",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 0, 0, 1'b0);
        step("inc_blocks", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 0, 0, 1'b0);

        // Write drain: three writes outstanding hold ISOLATE
        step("aw1",        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, 1, 0, 1'b0);
        step("aw2",        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, 2, 0, 1'b0);
        step("aw3_sleep",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_ISO, 3, 0, 1'b0);
        step("iso_wait",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ISO, 3, 0, 1'b0);
        step("b1",         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ISO, 2, 0, 1'b0);
        step("b2",         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ISO, 1, 0, 1'b0);
        step("b3",         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ISO, 0, 0, 1'b0);
        step("drain_cd",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CD,  0, 0, 1'b0);
        step("cd_aw",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_CD,  1, 0, 1'b0);
        step("cd_b",       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_CD,  0, 0, 1'b0);
        step("cd_exit",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_WK,  0, 0, 1'b0);
        for (int k = 0; k < WD - 1; k++)
            step("wake2_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_WK, 0, 0, 1'b0);
        step("wake2_run",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 0, 0, 1'b0);

        // Read side: abort ISOLATE on incoming request, simultaneous inc/dec holds
        step("ar1",        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN, 0, 1, 1'b0);
        step("ar2",        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN, 0, 2, 1'b0);
        step("rd_sleep",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ISO, 0, 2, 1'b0);
        step("rd_iso",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ISO, 0, 2, 1'b0);
        step("iso_inc",    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S_RUN, 0, 2, 1'b0);
        step("rd_run",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 0, 2, 1'b0);
        step("iso_again",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ISO, 0, 2, 1'b0);

        // Reset in the middle of ISOLATE
        sr = 1'b0;
        rst = 1'b1;
        #2;
        chk_reset("mid_rst_async");
        @(posedge clk);
        #1;
        chk_reset("mid_rst_held");
        rst = 1'b0;

        // Write saturation at MAX_OUTSTANDING
        for (int k = 1; k <= MAXO; k++)
            step("aw_fill", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, k, 0, 1'b0);
        step("aw_sat",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, MAXO, 0, 1'b1);
        step("aw_b_same",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_RUN, MAXO, 0, 1'b1);

        rst = 1'b1;
        #2;
        chk_reset("err_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Underflow: hold zero, sticky error
        step("b_at0",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_RUN, 0, 0, 1'b1);
        step("err_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 0, 0, 1'b1);
        step("r_at0",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_RUN, 0, 0, 1'b1);
        step("ar_one",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN, 0, 1, 1'b1);
        step("to_iso",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ISO, 0, 1, 1'b1);

`ifdef AXI_SLICE_DC_PWR_CTRL_TIMEOUT_EN
        for (int k = 1; k < DT; k++)
            step("to_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ISO, 0, 1, 1'b1);
        exp_to = 1'b1;
        step("to_fire",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CD,  0, 0, 1'b1);
        step("to_sticky",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CD,  0, 0, 1'b1);
`else
        for (int k = 1; k < DT + 4; k++)
            step("no_timeout", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ISO, 0, 1, 1'b1);
        step("late_drain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_ISO, 0, 0, 1'b1);
        step("late_cd",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CD,  0, 0, 1'b1);
`endif

        sr = 1'b0;
        rl = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
